// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store memory stage with single-outstanding data-memory handshake
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  rd_q, rd_d;

    logic        req_ready_q, req_ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        fault_q, fault_d;

    logic        req_legal, req_misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Classify the incoming request: legal width code for its direction, and natural alignment
    always_comb begin
        case (funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !is_store;
            default:                req_legal = 1'b0;
        endcase
        req_misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                         (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    end

    // Replicate store data across lanes and pick the byte enables for the addressed lane
    always_comb begin
        st_wdata = wdata;
        st_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{wdata[7:0]}};
                st_be    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{wdata[15:0]}};
                st_be    = 4'b0011 << addr[1:0];
            end
            default: ;
        endcase
    end

    // Select the addressed byte/halfword of the returned word and extend it per the latched width
    always_comb begin
        case (addr_lo_q)
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            3'b010:  ld_data = mem_rdata;
            default: ld_data = 32'd0;
        endcase
    end

    // Next-state and next-output logic; every output is the registered copy of its _d value
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + 32'd1;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        rd_d        = rd_q;
        req_ready_d = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'd0;
        mem_wdata_d = 32'd0;
        mem_be_d    = 4'd0;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = 5'd0;
        wb_data_d   = 32'd0;
        fault_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_lo_d  = addr[1:0];
                    rd_d       = rd;
                    cnt_d      = 32'd0;
                    if (req_legal && !req_misaligned) begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wdata_d = is_store ? st_wdata : 32'd0;
                        mem_be_d    = is_store ? st_be : 4'b1111;
                    end else begin
                        // Rejected before any memory traffic; report straight away
                        state_d    = ST_RESP;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        fault_d    = 1'b1;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d    = ST_RESP;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_we_d    = !is_store_q && (rd_q != 5'd0);
                    wb_data_d  = (!is_store_q && (rd_q != 5'd0)) ? ld_data : 32'd0;
                end else if (TIMEOUT_LIMIT != 32'd0 && cnt_inc == TIMEOUT_LIMIT) begin
                    cnt_d      = cnt_inc;
                    state_d    = ST_RESP;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    fault_d    = 1'b1;
                end else begin
                    // Keep the request and its attributes stable until the memory answers
                    cnt_d       = cnt_inc;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                    mem_be_d    = mem_be_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = 32'd0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State, latched request fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            rd_q        <= 5'd0;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            rd_q        <= rd_d;
            req_ready_q <= req_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            fault_q     <= fault_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign fault     = fault_q;
endmodule
